// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write queue between the core data port and a valid/ready data memory,
// with store-to-load forwarding; define STORE_BUFFER_COALESCE_EN to merge same-word stores into the youngest entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] ReadData,
    output logic          Full,
    output logic          Empty,
    output logic          Overflow,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail, tail_m1, widx;
    logic [PW:0]   count;
    logic          overflow_q, pop, push, coal, drop;

    assign Full       = count == FULL_CNT;
    assign Empty      = count == '0;
    assign Overflow   = overflow_q;
    assign mem_raddr  = DataAdr;
    assign mem_wvalid = !Empty;
    assign mem_waddr  = addr_q[head];
    assign mem_wdata  = data_q[head];
    assign pop        = mem_wvalid & mem_wready;
    assign tail_m1    = tail - PW'(1);
`ifdef STORE_BUFFER_COALESCE_EN
    // The head may already be on the bus, so it is never rewritten.
    assign coal = MemWrite && !Empty && addr_q[tail_m1][AW-1:2] == DataAdr[AW-1:2]
                  && !(tail_m1 == head && mem_wvalid);
`else
    assign coal = 1'b0;
`endif
    assign push = MemWrite & ~coal & (~Full | pop);
    assign drop = MemWrite & ~coal & ~push;
    assign widx = coal ? tail_m1 : tail;

    // Oldest to youngest, so the last match wins.
    always_comb begin
        ReadData = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && addr_q[head + PW'(i)][AW-1:2] == DataAdr[AW-1:2])
                ReadData = data_q[head + PW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (push) addr_q[widx] <= DataAdr;
        if (push | coal) data_q[widx] <= WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
            if (push & ~pop) count <= count + (PW+1)'(1);
            else if (pop & ~push) count <= count - (PW+1)'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table plus directed sequences for store_buffer; drained writes are checked against a scoreboard queue.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Full, Empty, Overflow;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = 32'hDEADBEEF;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;
    logic [31:0] mem_waddr, mem_wdata;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] sb_q [$];

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .Full(Full), .Empty(Empty),
        .Overflow(Overflow), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        wr;
        logic [31:0] rd;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        acc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so a handshake seen at negedge is the one the edge takes.
    always @(negedge clk) begin
        if (reset && mem_wvalid && mem_wready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_extra: got %h=%h expected no write", mem_waddr, mem_wdata);
            end else begin
                chk("drain_entry", {mem_waddr, mem_wdata}, sb_q.pop_front());
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_acc);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        if (exp_acc) sb_q.push_back({a, d});
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        MemWrite = 1'b0;
        mem_wready = 1'b1;
        @(negedge clk);
        while (!Empty && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_empty"}, 64'(Empty), 64'd1);
        chk({name, "_sb"}, 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [12];
        tv[0]  = '{1'b1, 32'h60, 32'd1, 1'b0, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 32'h64, 32'd2, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 32'h60, 32'd3, 1'b0, 32'd1,  1'b0, 1'b0, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 32'h60, 32'd0, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'h68, 32'd0, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 32'h6C, 32'd4, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 32'h62, 32'd0, 1'b0, 32'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 32'h74, 32'd5, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 32'h60, 32'd0, 1'b0, 32'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 32'h70, 32'd9, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 32'h70, 32'd0, 1'b0, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 32'h74, 32'd0, 1'b0, 32'd5,  1'b1, 1'b0, 1'b1, 1'b0};

        // Reset and idle
        DataAdr = 32'h10;
        #3;
        chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rdata", 64'(ReadData), 64'hDEADBEEF);
        chk("idle_raddr", 64'(mem_raddr), 64'h10);
        chk("idle_empty", 64'(Empty), 64'd1);
        chk("idle_wvalid", 64'(mem_wvalid), 64'd0);
        chk("idle_ovf", 64'(Overflow), 64'd0);
        @(posedge clk);
        #1;

        // Single store held by a stalled memory
        mem_wready = 1'b0;
        MemWrite = 1'b1;
        DataAdr = 32'h64;
        WriteData = 32'd7;
        sb_q.push_back({32'h64, 32'd7});
        @(negedge clk);
        chk("st_nofwd", 64'(ReadData), 64'hDEADBEEF);
        chk("st_wvalid0", 64'(mem_wvalid), 64'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_wready = (c == 3);
            @(negedge clk);
            chk($sformatf("hold%0d_wvalid", c), 64'(mem_wvalid), 64'd1);
            chk($sformatf("hold%0d_waddr", c), 64'(mem_waddr), 64'h64);
            chk($sformatf("hold%0d_wdata", c), 64'(mem_wdata), 64'd7);
            if (c == 3) chk("pop_fwd", 64'(ReadData), 64'd7);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("after_pop_empty", 64'(Empty), 64'd1);
        chk("after_pop_wvalid", 64'(mem_wvalid), 64'd0);
        chk("after_pop_sb", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Forwarding, full, push-with-pop at full, overflow
        mem_rdata = 32'h55;
        for (int i = 0; i < 12; i++) begin
            MemWrite = tv[i].we;
            DataAdr = tv[i].adr;
            WriteData = tv[i].wd;
            mem_wready = tv[i].wr;
            if (tv[i].acc) sb_q.push_back({tv[i].adr, tv[i].wd});
            @(negedge clk);
            chk($sformatf("v%0d_rdata", i), 64'(ReadData), 64'(tv[i].rd));
            chk($sformatf("v%0d_full", i), 64'(Full), 64'(tv[i].full));
            chk($sformatf("v%0d_empty", i), 64'(Empty), 64'(tv[i].empty));
            chk($sformatf("v%0d_ovf", i), 64'(Overflow), 64'(tv[i].ovf));
            @(posedge clk);
            #1;
        end
        drain("ovf_drain");
        chk("ovf_sticky", 64'(Overflow), 64'd1);

        // Async reset mid-handshake
        mem_wready = 1'b0;
        store(32'h90, 32'd11, 1'b1);
        store(32'h94, 32'd12, 1'b1);
        store(32'h98, 32'd13, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_wvalid", 64'(mem_wvalid), 64'd0);
        chk("arst_empty", 64'(Empty), 64'd1);
        chk("arst_full", 64'(Full), 64'd0);
        chk("arst_ovf", 64'(Overflow), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_wready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_wvalid", c), 64'(mem_wvalid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Same-word stores behind a stalled head
        mem_wready = 1'b0;
        store(32'h80, 32'd7, 1'b1);
        store(32'h80, 32'd1, 1'b1);
`ifdef STORE_BUFFER_COALESCE_EN
        store(32'h80, 32'd2, 1'b0);
        sb_q[1] = {32'h80, 32'd2};
`else
        store(32'h80, 32'd2, 1'b1);
`endif
        DataAdr = 32'h80;
        @(negedge clk);
        chk("coal_fwd", 64'(ReadData), 64'd2);
        chk("coal_ovf", 64'(Overflow), 64'd0);
        @(posedge clk);
        #1;
        drain("coal_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData/ReadData) and a data memory that accepts writes over a valid/ready handshake and may take several cycles per write.
- Stores retire from the core in one cycle and are queued in order.
- The buffer drains them to memory one at a time.
- Loads read through the buffer with store-to-load forwarding, so the core never sees stale data.

Parameters:
DEPTH, 4, number of queued stores (power of 2, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
MemWrite  in  1  core store request this cycle
DataAdr  in  AW  core load/store byte address (word aligned, bits [1:0] ignored)
WriteData  in  DW  core store data
ReadData  out  DW  load data to core (forwarded or from memory)
Full  out  1  count==DEPTH
Empty  out  1  count==0
Overflow  out  1  sticky: store dropped
mem_raddr  out  AW  memory read address, equal to DataAdr (combinational)
mem_rdata  in  DW  memory combinational read data
mem_wvalid  out  1  head entry valid for write
mem_wready  in  1  memory accepts write
mem_waddr  out  AW  head entry address
mem_wdata  out  DW  head entry data

Behaviour:
- Storage: circular FIFO of DEPTH {addr, data} entries.
  - Head pointer, tail pointer and count are registered; the count is $clog2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
- Reset (reset==0, async):
  - head, tail and count are set to 0; Overflow=0.
  - Outputs are forced immediately: mem_wvalid=0, Empty=1, Full=0.
  - Queued stores are discarded, including one mid-handshake.
  - Entry contents are don't-care.
- pop = mem_wvalid & mem_wready.
- Drain side:
  - mem_wvalid = (count!=0).
  - mem_waddr and mem_wdata present the head entry.
  - These are stable while mem_wvalid & ~mem_wready.
  - On pop, head advances at the clock edge. Latency from empty to mem_wvalid is one cycle after the store is accepted.
- Push:
  - A push is accepted when MemWrite and (count<DEPTH or pop).
  - The entry is written at tail and tail advances.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at count==DEPTH.
- MemWrite while count==DEPTH and no pop: the store is dropped and Overflow is set to 1, held until reset.
- Count update: +1 on push only, -1 on pop only.
- Forwarding:
  - When there is no matching entry, ReadData = mem_rdata.
  - Otherwise ReadData = data of the youngest valid entry whose addr[AW-1:2] equals DataAdr[AW-1:2].
  - Forwarding is combinational on the current (pre-edge) contents, so an entry being popped this cycle still forwards.
  - The same-cycle incoming store is not forwarded.
  - Entries outside [head, head+count) never match.
- Full and Empty are combinational decodes of the registered count only. They do not look at the same-cycle pop.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- With the macro defined, a push is coalesced when all of these hold:
  - count!=0;
  - the store's word address equals the youngest entry's (tail-1);
  - that entry is not the head while mem_wvalid==1.
- A coalesced push overwrites the youngest entry's data in place. Tail and count are unchanged.
- A coalesced push is accepted even when count==DEPTH and does not set Overflow.
- Without the macro, every accepted store allocates a new entry.

Test Plan:
1. Reset then idle with mem_wready=1: Empty=1, mem_wvalid=0, ReadData follows mem_rdata (e.g. 0xDEADBEEF).
2. Store addr 0x64 data 7, mem_wready=0 for 3 cycles then 1:
   - mem_wvalid=1 with waddr 0x64 / wdata 7 stable for 4 cycles;
   - one pop; Empty=1 the next cycle.
3. mem_wready=0; stores to 0x60=1, 0x64=2, 0x60=3; load 0x60:
   - ReadData=3 (youngest wins), ignoring mem_rdata=0x55;
   - load 0x68 returns 0x55.
4. mem_wready=0; 4 stores to distinct addresses, then Full=1; a 5th store (0x70=9):
   - Overflow=1; count stays 4;
   - drain order matches push order; 0x70 is never written.
5. Full with mem_wready=1 and a same-cycle store (0x74=5): accepted, Overflow stays 0, count stays 4, 0x74 drained last.
6. reset pulsed low mid-handshake (count=3, mem_wready=0): mem_wvalid drops to 0 without waiting for clk, Empty=1. With STORE_BUFFER_COALESCE_EN, two stores to 0x80 (1 then 2) behind a stalled head leave count=2 and drain 0x80=2 once.
